// File: rtl/pgm_gen_rd.sv
`default_nettype none
// ============================================================================
// Module   : pgm_gen_rd
// Brief    : Multi-template packet generator read engine. Replays enabled
//            PGM RAM templates in round-robin order with a programmable
//            inter-packet gap, optional packet limit and graceful stop.
// Options  : PGM_STAMP_EN - stamp {sequence, timestamp, FFFFFFFF} into the
//            payload of beat STAMP_BEAT.
// Revision : 1.0 - initial release
// ============================================================================
module pgm_gen_rd #(
  parameter int TPL_NUM    = 4,
  parameter int TPL_DEPTH  = 32,
  parameter int ADDR_W     = 7,
  parameter int STAMP_BEAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [TPL_NUM-1:0]  i_tpl_mask,
  input  logic [31:0]         i_gap_cycles,
  input  logic [31:0]         i_pkt_limit,
  input  logic                i_in_alf,
  input  logic [31:0]         i_timestamp,
  output logic                o_ram_rd,
  output logic [ADDR_W-1:0]   o_ram_addr,
  input  logic [143:0]        i_ram_rdata,
  output logic [133:0]        o_out_data,
  output logic                o_out_data_wr,
  output logic                o_out_valid,
  output logic                o_out_valid_wr,
  output logic [1023:0]       o_out_phv,
  output logic                o_out_phv_wr,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_overrun,
  output logic [63:0]         o_sent_pkt_cnt,
  output logic [63:0]         o_sent_byte_cnt
);

  localparam int TPL_IDX_W = 3;
  localparam int BEAT_W    = (TPL_DEPTH > 1) ? $clog2(TPL_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_READ  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [TPL_NUM-1:0]     r_mask;
  logic [31:0]            r_gap;
  logic [31:0]            r_limit;
  logic                   r_stop;
  logic [TPL_IDX_W-1:0]   r_tpl;
  logic [TPL_IDX_W-1:0]   r_phv_tpl;
  logic [BEAT_W-1:0]      r_beat;
  logic [32:0]            r_gap_cnt;

  logic                   w_is_tail;
  logic                   w_last_beat;
  logic                   w_overrun;
  logic                   w_end;
  logic [63:0]            w_pkt_next;
  logic                   w_limit_hit;
  logic                   w_stop_any;
  logic                   w_gap_done;
  logic [63:0]            w_bytes;
  logic [133:0]           w_beat;
  logic [TPL_IDX_W-1:0]   w_next_tpl;

  // Lowest enabled slot; used at start and as the round-robin wrap target.
  function automatic logic [TPL_IDX_W-1:0] f_lowest(input logic [TPL_NUM-1:0] mask);
    f_lowest = '0;
    for (int i = TPL_NUM - 1; i >= 0; i--) begin
      if (mask[i]) f_lowest = TPL_IDX_W'(i);
    end
  endfunction

  function automatic logic [ADDR_W-1:0] f_base(input logic [TPL_IDX_W-1:0] idx);
    f_base = ADDR_W'(int'(idx) * TPL_DEPTH);
  endfunction

  assign w_is_tail   = (i_ram_rdata[133:132] == 2'b10);
  assign w_last_beat = (r_beat == BEAT_W'(TPL_DEPTH - 1));
  assign w_overrun   = w_last_beat & ~w_is_tail;
  assign w_end       = w_is_tail | w_last_beat;
  assign w_pkt_next  = o_sent_pkt_cnt + 64'd1;
  assign w_limit_hit = (r_limit != 32'd0) && (w_pkt_next == {32'd0, r_limit});
  assign w_stop_any  = r_stop | i_stop;
  // Gap phase spends gap+1 counting cycles so tail-to-head is gap+3 idle cycles.
  assign w_gap_done  = (r_gap_cnt == ({1'b0, r_gap} + 33'd1));
  assign w_bytes     = w_end ? {60'd0, (w_overrun ? 4'd0 : i_ram_rdata[131:128])} : 64'd16;

  assign o_busy    = (r_state == ST_FETCH) || (r_state == ST_READ) || (r_state == ST_GAP);
  assign o_done    = (r_state == ST_DONE);
  assign o_out_phv = {{(1024 - TPL_IDX_W){1'b0}}, r_phv_tpl};

  // Next enabled slot above the current one, wrapping to the lowest.
  always_comb begin
    w_next_tpl = f_lowest(r_mask);
    for (int i = TPL_NUM - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_tpl))) w_next_tpl = TPL_IDX_W'(i);
    end
  end

  // Beat shaping: overrun forces a zero-count tail; stamping rewrites payload only.
  always_comb begin
    w_beat = i_ram_rdata[133:0];
    if (w_overrun) begin
      w_beat[133:128] = 6'b10_0000;
    end
`ifdef PGM_STAMP_EN
    else if (!w_is_tail && (r_beat == BEAT_W'(STAMP_BEAT))) begin
      w_beat[127:0] = {o_sent_pkt_cnt, i_timestamp, 32'hFFFF_FFFF};
    end
`endif
  end

`ifdef PGM_STAMP_EN
  logic w_unused_ok;
  assign w_unused_ok = ^i_ram_rdata[143:134];
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{i_ram_rdata[143:134], i_timestamp};
`endif

  // Main controller: sequencing, RAM addressing, beat output and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_mask          <= '0;
      r_gap           <= '0;
      r_limit         <= '0;
      r_stop          <= 1'b0;
      r_tpl           <= '0;
      r_phv_tpl       <= '0;
      r_beat          <= '0;
      r_gap_cnt       <= '0;
      o_ram_rd        <= 1'b0;
      o_ram_addr      <= '0;
      o_out_data      <= '0;
      o_out_data_wr   <= 1'b0;
      o_out_valid     <= 1'b0;
      o_out_valid_wr  <= 1'b0;
      o_out_phv_wr    <= 1'b0;
      o_err_overrun   <= 1'b0;
      o_sent_pkt_cnt  <= '0;
      o_sent_byte_cnt <= '0;
    end else begin
      o_out_data_wr  <= 1'b0;
      o_out_valid    <= 1'b0;
      o_out_valid_wr <= 1'b0;
      o_out_phv_wr   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start && !i_stop && (|i_tpl_mask)) begin
            r_mask          <= i_tpl_mask;
            r_gap           <= i_gap_cycles;
            r_limit         <= i_pkt_limit;
            r_stop          <= 1'b0;
            r_tpl           <= f_lowest(i_tpl_mask);
            o_err_overrun   <= 1'b0;
            o_sent_pkt_cnt  <= '0;
            o_sent_byte_cnt <= '0;
            o_ram_rd        <= 1'b1;
            o_ram_addr      <= f_base(f_lowest(i_tpl_mask));
            r_state         <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_stop     <= w_stop_any;
          o_ram_addr <= o_ram_addr + ADDR_W'(1);
          r_beat     <= '0;
          r_state    <= ST_READ;
        end
        ST_READ: begin
          r_stop          <= w_stop_any;
          o_out_data      <= w_beat;
          o_out_data_wr   <= 1'b1;
          o_ram_addr      <= o_ram_addr + ADDR_W'(1);
          r_beat          <= r_beat + BEAT_W'(1);
          o_sent_byte_cnt <= o_sent_byte_cnt + w_bytes;
          if (r_beat == '0) begin
            o_out_phv_wr <= 1'b1;
            r_phv_tpl    <= r_tpl;
          end
          if (w_end) begin
            o_out_valid    <= 1'b1;
            o_out_valid_wr <= 1'b1;
            o_ram_rd       <= 1'b0;
            o_sent_pkt_cnt <= w_pkt_next;
            r_gap_cnt      <= '0;
            if (w_overrun) o_err_overrun <= 1'b1;
            if (w_limit_hit)     r_state <= ST_DONE;
            else if (w_stop_any) r_state <= ST_IDLE;
            else                 r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_stop <= w_stop_any;
          if (!w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + 33'd1;
          end else if (!i_in_alf) begin
            r_tpl      <= w_next_tpl;
            o_ram_rd   <= 1'b1;
            o_ram_addr <= f_base(w_next_tpl);
            r_state    <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pgm_gen_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgm_gen_rd
// Brief    : Self-checking bench for pgm_gen_rd with randomized templates and
//            a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgm_gen_rd;

  localparam int TPL_NUM    = 4;
  localparam int TPL_DEPTH  = 32;
  localparam int ADDR_W     = 7;
  localparam int STAMP_BEAT = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_start, i_stop, i_in_alf;
  logic [TPL_NUM-1:0]  i_tpl_mask;
  logic [31:0]         i_gap_cycles, i_pkt_limit, i_timestamp;
  logic                o_ram_rd;
  logic [ADDR_W-1:0]   o_ram_addr;
  logic [143:0]        i_ram_rdata = '0;
  logic [133:0]        o_out_data;
  logic                o_out_data_wr, o_out_valid, o_out_valid_wr;
  logic [1023:0]       o_out_phv;
  logic                o_out_phv_wr, o_busy, o_done, o_err_overrun;
  logic [63:0]         o_sent_pkt_cnt, o_sent_byte_cnt;

  pgm_gen_rd #(
    .TPL_NUM(TPL_NUM), .TPL_DEPTH(TPL_DEPTH), .ADDR_W(ADDR_W), .STAMP_BEAT(STAMP_BEAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_tpl_mask(i_tpl_mask), .i_gap_cycles(i_gap_cycles), .i_pkt_limit(i_pkt_limit),
    .i_in_alf(i_in_alf), .i_timestamp(i_timestamp), .o_ram_rd(o_ram_rd),
    .o_ram_addr(o_ram_addr), .i_ram_rdata(i_ram_rdata), .o_out_data(o_out_data),
    .o_out_data_wr(o_out_data_wr), .o_out_valid(o_out_valid), .o_out_valid_wr(o_out_valid_wr),
    .o_out_phv(o_out_phv), .o_out_phv_wr(o_out_phv_wr), .o_busy(o_busy), .o_done(o_done),
    .o_err_overrun(o_err_overrun), .o_sent_pkt_cnt(o_sent_pkt_cnt),
    .o_sent_byte_cnt(o_sent_byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Template RAM with one cycle read latency.
  logic [143:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (o_ram_rd) i_ram_rdata <= ram[o_ram_addr];

  typedef struct packed {
    logic [133:0] data;
    logic         head;
    logic         tail;
    logic [7:0]   tpl;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] m_pkts, m_bytes;
  logic        m_err;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 0;
  bit          first_head, alf_touched;
  int          start_cyc, last_tail, gap_cur, alf_rel_cyc;

  task automatic chk(input string tag, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Fill one slot: head, mids, tail with count tcnt at beat len-1 (or no tail at all).
  task automatic gen_slot(input int slot, input int len, input logic [3:0] tcnt, input bit no_tail);
    logic [159:0] r;
    logic [143:0] w;
    for (int b = 0; b < TPL_DEPTH; b++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      w = r[143:0];
      if (no_tail || b < len - 1) begin
        w[133:132] = (b == 0) ? 2'b01 : 2'b11;
      end else if (b == len - 1) begin
        w[133:132] = 2'b10;
        w[131:128] = tcnt;
      end else begin
        w[133:132] = 2'b11;
      end
      ram[slot * TPL_DEPTH + b] = w;
    end
  endtask

  // Packet-level expectation: round-robin over the mask, stop at the tail or slot end.
  task automatic build_model(input logic [TPL_NUM-1:0] mask, input int npkt);
    int    cur;
    int    c;
    bit    tail;
    logic [133:0] w;
    beat_t bt;
    cur = -1;
    exp_q.delete();
    m_pkts = 0; m_bytes = 0; m_err = 0;
    for (int p = 0; p < npkt; p++) begin
      for (int k = 1; k <= TPL_NUM; k++) begin
        c = (cur + k + TPL_NUM) % TPL_NUM;
        if (mask[c]) begin
          cur = c;
          break;
        end
      end
      for (int b = 0; b < TPL_DEPTH; b++) begin
        w = ram[cur * TPL_DEPTH + b][133:0];
        tail = (w[133:132] == 2'b10);
        if (!tail && b == TPL_DEPTH - 1) begin
          w[133:128] = 6'b100000;
          tail = 1;
          m_err = 1;
        end
`ifdef PGM_STAMP_EN
        else if (!tail && b == STAMP_BEAT) begin
          w[127:0] = {m_pkts, i_timestamp, 32'hFFFFFFFF};
        end
`endif
        if (tail) m_bytes = m_bytes + 64'(w[131:128]);
        else      m_bytes = m_bytes + 64'd16;
        bt.data = w;
        bt.head = (b == 0);
        bt.tail = tail;
        bt.tpl  = 8'(cur);
        exp_q.push_back(bt);
        if (tail) break;
      end
      m_pkts = m_pkts + 64'd1;
    end
  endtask

  // Output monitor: every beat against the model, plus head latency and gap timing.
  always @(negedge clk) begin
    beat_t e;
    if (mon_en && o_out_data_wr) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", o_out_data, e.data);
        chk("phv_wr", o_out_phv_wr, e.head);
        chk("valid_wr", o_out_valid_wr, e.tail);
        chk("valid", o_out_valid, e.tail);
        if (e.head) begin
          chk("phv", {|o_out_phv[1023:8], o_out_phv[7:0]}, {1'b0, e.tpl});
          if (first_head)       chk("head_lat", cyc - start_cyc, 2);
          else if (alf_touched) chk("alf_head", cyc - alf_rel_cyc, 3);
          else                  chk("gap_idle", cyc - last_tail - 1, gap_cur + 3);
          if (!first_head) alf_touched = 0;
          first_head = 0;
        end
        if (e.tail) last_tail = cyc;
      end
    end
  end

  task automatic do_start(input logic [TPL_NUM-1:0] mask, input logic [31:0] gap, input logic [31:0] lim);
    first_head = 1; alf_touched = 0; gap_cur = int'(gap); mon_en = 1;
    @(negedge clk);
    i_start = 1; i_tpl_mask = mask; i_gap_cycles = gap; i_pkt_limit = lim;
    start_cyc = cyc + 1;
    @(negedge clk);
    i_start = 0;
    chk("busy_after_start", o_busy, 1'b1);
    chk("err_clr", o_err_overrun, 1'b0);
    chk("pkt_clr", o_sent_pkt_cnt, 64'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", o_busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic end_checks(input bit exp_done);
    chk("q_empty", 134'(exp_q.size()), 134'd0);
    chk("pkt_cnt", o_sent_pkt_cnt, m_pkts);
    chk("byte_cnt", o_sent_byte_cnt, m_bytes);
    chk("err", o_err_overrun, m_err);
    chk("done", o_done, exp_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [TPL_NUM-1:0] mask;
    int lim;
    i_start = 0; i_stop = 0; i_in_alf = 0; i_tpl_mask = '0;
    i_gap_cycles = '0; i_pkt_limit = '0; i_timestamp = $urandom;
    for (int s = 0; s < TPL_NUM; s++) gen_slot(s, 8, 4'd8, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_ram_rd", o_ram_rd, 1'b0);
    chk("rst_wr", o_out_data_wr, 1'b0);
    chk("rst_data", o_out_data, '0);
    chk("rst_pkt", o_sent_pkt_cnt, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // Single 6-beat packet from slot 0
    gen_slot(0, 6, 4'd4, 0);
    build_model(4'b0001, 1);
    do_start(4'b0001, 0, 1);
    wait_idle(200);
    end_checks(1);
    chk("single_pkts", o_sent_pkt_cnt, 64'd1);
    chk("single_bytes", o_sent_byte_cnt, 64'd84);

    // Round robin over slots 1 and 3 with gap 5
    gen_slot(1, $urandom_range(3, 10), 4'($urandom), 0);
    gen_slot(3, $urandom_range(3, 10), 4'($urandom), 0);
    build_model(4'b1010, 4);
    do_start(4'b1010, 5, 4);
    wait_idle(400);
    end_checks(1);

    // Overrun slot without a tail
    gen_slot(2, 32, 4'd0, 1);
    build_model(4'b0100, 2);
    do_start(4'b0100, 1, 2);
    wait_idle(200);
    end_checks(1);
    chk("ovr_err", o_err_overrun, 1'b1);
    chk("ovr_bytes", o_sent_byte_cnt, 64'd992);

    // Backpressure held during the gap
    gen_slot(0, $urandom_range(4, 8), 4'($urandom), 0);
    gen_slot(1, $urandom_range(4, 8), 4'($urandom), 0);
    build_model(4'b0011, 3);
    do_start(4'b0011, 2, 3);
    n = 0;
    while (o_out_valid_wr !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_tail_seen", o_out_valid_wr, 1'b1);
    i_in_alf = 1;
    alf_touched = 1;
    alf_rel_cyc = cyc + 20;
    repeat (20) @(negedge clk);
    i_in_alf = 0;
    wait_idle(300);
    end_checks(1);

    // Graceful stop mid-packet, unlimited run
    gen_slot(0, $urandom_range(5, 12), 4'($urandom), 0);
    gen_slot(1, $urandom_range(5, 12), 4'($urandom), 0);
    build_model(4'b0011, 1);
    do_start(4'b0011, 1, 0);
    @(negedge clk);
    @(negedge clk);
    i_stop = 1;
    @(negedge clk);
    i_stop = 0;
    wait_idle(200);
    end_checks(0);

    // Stop together with start suppresses the start
    @(negedge clk);
    i_start = 1; i_stop = 1; i_tpl_mask = 4'b0001;
    @(negedge clk);
    i_start = 0; i_stop = 0;
    chk("stopstart_busy", o_busy, 1'b0);
    chk("stopstart_rd", o_ram_rd, 1'b0);

    // Randomized runs
    for (int it = 0; it < 5; it++) begin
      for (int s = 0; s < TPL_NUM; s++)
        gen_slot(s, $urandom_range(1, 32), 4'($urandom), ($urandom_range(0, 5) == 0));
      mask = 4'($urandom_range(1, 15));
      lim = $urandom_range(1, 5);
      i_timestamp = $urandom;
      build_model(mask, lim);
      do_start(mask, 32'($urandom_range(0, 6)), 32'(lim));
      wait_idle(600);
      end_checks(1);
    end

    // Asynchronous reset mid-packet
    gen_slot(0, 20, 4'd3, 0);
    do_start(4'b0001, 0, 0);
    mon_en = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_wr", o_out_data_wr, 1'b0);
    chk("arst_data", o_out_data, '0);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_rd", o_ram_rd, 1'b0);
    chk("arst_bytes", o_sent_byte_cnt, 64'd0);
    chk("arst_phv", {|o_out_phv, o_out_phv_wr, o_out_valid_wr}, 3'b000);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 1'b0);

    // Start with an empty mask is ignored
    i_start = 1; i_tpl_mask = '0;
    @(negedge clk);
    i_start = 0;
    chk("mask0_busy", o_busy, 1'b0);
    chk("mask0_rd", o_ram_rd, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mask0_wr", o_out_data_wr, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
